// File: rtl/wb_pkg.sv
// Shared types for the writeback controller: result record, grant encoding and widths.
package wb_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REG_AW   = 5;
  localparam int NREGS    = 1 << REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0]   rd;
    logic [XLEN_DEF-1:0] data;
  } wb_req_t;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LSU = 1'b1
  } wb_gnt_e;

  function automatic wb_gnt_e other_gnt(input wb_gnt_e g);
    return (g == GNT_ALU) ? GNT_LSU : GNT_ALU;
  endfunction

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Bundle of issue, decode, result and register-set write signals around regfile_wb_ctrl.
// Forwarding outputs exist only when WB_BYPASS_EN is defined.
interface regfile_wb_ctrl_if #(
    parameter int XLEN = wb_pkg::XLEN_DEF
);
    import wb_pkg::*;

    logic                 i_issue_valid;
    logic [REG_AW-1:0]    i_issue_rd;
    logic                 i_issue_wb;
    logic [REG_AW-1:0]    i_rs1_addr;
    logic [REG_AW-1:0]    i_rs2_addr;
    logic                 o_hazard;

    logic                 i_alu_valid;
    logic [REG_AW-1:0]    i_alu_rd;
    logic [XLEN-1:0]      i_alu_data;
    logic                 o_alu_ready;

    logic                 i_lsu_valid;
    logic [REG_AW-1:0]    i_lsu_rd;
    logic [XLEN-1:0]      i_lsu_data;
    logic                 o_lsu_ready;

    logic [REG_AW-1:0]    o_wr_addr;
    logic [XLEN-1:0]      o_wr_data;
    logic                 o_wr_wren;
    logic [NREGS-1:0]     o_busy;

`ifdef WB_BYPASS_EN
    logic [XLEN-1:0]      o_fwd_rs1;
    logic [XLEN-1:0]      o_fwd_rs2;
    logic                 o_fwd_rs1_hit;
    logic                 o_fwd_rs2_hit;
`endif

    modport slave (
        input  i_issue_valid, i_issue_rd, i_issue_wb, i_rs1_addr, i_rs2_addr,
        input  i_alu_valid, i_alu_rd, i_alu_data,
        input  i_lsu_valid, i_lsu_rd, i_lsu_data,
`ifdef WB_BYPASS_EN
        output o_fwd_rs1, o_fwd_rs2, o_fwd_rs1_hit, o_fwd_rs2_hit,
`endif
        output o_hazard, o_alu_ready, o_lsu_ready,
        output o_wr_addr, o_wr_data, o_wr_wren, o_busy
    );

    modport master (
        output i_issue_valid, i_issue_rd, i_issue_wb, i_rs1_addr, i_rs2_addr,
        output i_alu_valid, i_alu_rd, i_alu_data,
        output i_lsu_valid, i_lsu_rd, i_lsu_data,
`ifdef WB_BYPASS_EN
        input  o_fwd_rs1, o_fwd_rs2, o_fwd_rs1_hit, o_fwd_rs2_hit,
`endif
        input  o_hazard, o_alu_ready, o_lsu_ready,
        input  o_wr_addr, o_wr_data, o_wr_wren, o_busy
    );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of load results; DEPTH must be a power of two >= 2.
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  wb_req_t       i_data,
    input  logic          i_pop,
    output wb_req_t       o_data,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    wb_req_t       mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign push_ok = i_push & ~o_full;
    assign pop_ok  = i_pop & ~o_empty;
    assign o_count = count_q;
    assign o_data  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define validity.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= i_data;
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: arbitrates ALU and buffered load results onto the register-set write
// port and tracks pending destinations. Define WB_BYPASS_EN to add write-port forwarding.
module regfile_wb_ctrl
    import wb_pkg::*;
#(
    parameter int XLEN          = XLEN_DEF,
    parameter int LD_FIFO_DEPTH = 4
) (
    input logic               i_clk,
    input logic               i_rst,
    regfile_wb_ctrl_if.slave  bus
);

    localparam int FCW = $clog2(LD_FIFO_DEPTH) + 1;

    wb_req_t          lsu_in, lsu_head, alu_req, win_req;
    logic [FCW-1:0]   fifo_count;
    logic             fifo_full, fifo_empty;
    logic             lsu_ready, lsu_push, lsu_pop;

    logic             gnt_valid;
    wb_gnt_e          gnt_sel;
    wb_gnt_e          rr_q, rr_d;

    logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
    logic [XLEN-1:0]   wr_data_q, wr_data_d;
    logic              wr_wren_q, wr_wren_d;
    logic [NREGS-1:0]  busy_q, busy_d;

    logic              rs1_pend, rs2_pend;

    assign lsu_in.rd    = bus.i_lsu_rd;
    assign lsu_in.data  = bus.i_lsu_data;
    assign alu_req.rd   = bus.i_alu_rd;
    assign alu_req.data = bus.i_alu_data;

    assign lsu_ready = (fifo_count < FCW'(LD_FIFO_DEPTH));
    assign lsu_push  = bus.i_lsu_valid & lsu_ready;
    assign lsu_pop   = gnt_valid & (gnt_sel == GNT_LSU);

    wb_fifo #(
        .DEPTH (LD_FIFO_DEPTH)
    ) u_ld_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (lsu_push),
        .i_data  (lsu_in),
        .i_pop   (lsu_pop),
        .o_data  (lsu_head),
        .o_count (fifo_count),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // A full FIFO must drain, otherwise the load unit would stall indefinitely.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_sel   = rr_q;
        rr_d      = rr_q;
        if (fifo_full) begin
            gnt_valid = 1'b1;
            gnt_sel   = GNT_LSU;
        end else if (bus.i_alu_valid && !fifo_empty) begin
            gnt_valid = 1'b1;
            gnt_sel   = rr_q;
        end else if (bus.i_alu_valid) begin
            gnt_valid = 1'b1;
            gnt_sel   = GNT_ALU;
        end else if (!fifo_empty) begin
            gnt_valid = 1'b1;
            gnt_sel   = GNT_LSU;
        end
        if (gnt_valid) rr_d = other_gnt(gnt_sel);
    end

    assign win_req = (gnt_sel == GNT_LSU) ? lsu_head : alu_req;

    always_comb begin
        wr_wren_d = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (gnt_valid && win_req.rd != '0) begin
            wr_wren_d = 1'b1;
            wr_addr_d = win_req.rd;
            wr_data_d = win_req.data;
        end
    end

    // Set is applied after clear so a same-edge reissue of the retiring rd stays pending.
    always_comb begin
        busy_d = busy_q;
        if (wr_wren_q) busy_d[wr_addr_q] = 1'b0;
        if (bus.i_issue_valid && bus.i_issue_wb && bus.i_issue_rd != '0)
            busy_d[bus.i_issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_q      <= GNT_ALU;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_wren_q <= 1'b0;
            busy_q    <= '0;
        end else begin
            rr_q      <= rr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_wren_q <= wr_wren_d;
            busy_q    <= busy_d;
        end
    end

    assign rs1_pend = busy_q[bus.i_rs1_addr];
    assign rs2_pend = busy_q[bus.i_rs2_addr];

`ifdef WB_BYPASS_EN
    logic rs1_hit, rs2_hit;

    assign rs1_hit = wr_wren_q && (wr_addr_q == bus.i_rs1_addr) && (bus.i_rs1_addr != '0);
    assign rs2_hit = wr_wren_q && (wr_addr_q == bus.i_rs2_addr) && (bus.i_rs2_addr != '0);

    assign bus.o_fwd_rs1_hit = rs1_hit;
    assign bus.o_fwd_rs2_hit = rs2_hit;
    assign bus.o_fwd_rs1     = wr_data_q;
    assign bus.o_fwd_rs2     = wr_data_q;
    assign bus.o_hazard      = (rs1_pend & ~rs1_hit) | (rs2_pend & ~rs2_hit);
`else
    assign bus.o_hazard      = rs1_pend | rs2_pend;
`endif

    assign bus.o_alu_ready = fifo_empty | (gnt_valid & (gnt_sel == GNT_ALU));
    assign bus.o_lsu_ready = lsu_ready;
    assign bus.o_wr_addr   = wr_addr_q;
    assign bus.o_wr_data   = wr_data_q;
    assign bus.o_wr_wren   = wr_wren_q;
    assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Scoreboard bench for regfile_wb_ctrl: expected writes are queued per source on handshake
// and popped as the write port fires.
module tb_regfile_wb_ctrl;
    import wb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    logic alu_acc, lsu_acc;

    wb_req_t alu_exp[$];
    wb_req_t lsu_exp[$];
    bit      src_log[$];

    regfile_wb_ctrl_if #(.XLEN(32)) bus ();

    regfile_wb_ctrl #(
        .XLEN          (32),
        .LD_FIFO_DEPTH (4)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One cycle: at negedge check any write against the queue heads, then log handshakes.
    task automatic tick();
        wb_req_t got, e;
        @(negedge clk);
        alu_acc = 1'b0;
        lsu_acc = 1'b0;
        if (rst) begin
            alu_exp.delete();
            lsu_exp.delete();
        end else begin
            if (bus.o_wr_wren) begin
                got.rd   = bus.o_wr_addr;
                got.data = bus.o_wr_data;
                vectors++;
                if (alu_exp.size() > 0 && alu_exp[0] == got) begin
                    void'(alu_exp.pop_front());
                    src_log.push_back(1'b0);
                end else if (lsu_exp.size() > 0 && lsu_exp[0] == got) begin
                    void'(lsu_exp.pop_front());
                    src_log.push_back(1'b1);
                end else begin
                    miscompares++;
                    $display("FAIL wb_write: got rd=%0d data=%h, no matching queued result (alu %0d, lsu %0d queued)",
                             got.rd, got.data, alu_exp.size(), lsu_exp.size());
                end
            end
            alu_acc = bus.i_alu_valid && bus.o_alu_ready;
            lsu_acc = bus.i_lsu_valid && bus.o_lsu_ready;
            if (alu_acc && bus.i_alu_rd != 5'd0) begin
                e.rd = bus.i_alu_rd; e.data = bus.i_alu_data; alu_exp.push_back(e);
            end
            if (lsu_acc && bus.i_lsu_rd != 5'd0) begin
                e.rd = bus.i_lsu_rd; e.data = bus.i_lsu_data; lsu_exp.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (bus.o_wr_wren !== 1'b0) begin miscompares++; $display("FAIL reset_wren: got %b want 0", bus.o_wr_wren); end
        vectors++; if (bus.o_busy !== 32'h0) begin miscompares++; $display("FAIL reset_busy: got %h want 0", bus.o_busy); end
        vectors++; if (bus.o_wr_addr !== 5'd0 || bus.o_wr_data !== 32'h0) begin miscompares++; $display("FAIL reset_wr_bus: got addr %0d data %h want 0/0", bus.o_wr_addr, bus.o_wr_data); end
        rst = 1'b0;
        tick();
        vectors++; if (bus.o_lsu_ready !== 1'b1) begin miscompares++; $display("FAIL reset_lsu_ready: got %b want 1", bus.o_lsu_ready); end
        vectors++; if (bus.o_hazard !== 1'b0) begin miscompares++; $display("FAIL reset_hazard: got %b want 0", bus.o_hazard); end
    endtask

    task automatic test_alu_write();
        bus.i_issue_valid = 1'b1; bus.i_issue_wb = 1'b1; bus.i_issue_rd = 5'd5;
        bus.i_rs1_addr = 5'd5;
        tick();
        bus.i_issue_valid = 1'b0;
        vectors++; if (bus.o_busy[5] !== 1'b1) begin miscompares++; $display("FAIL issue_busy5: got %b want 1", bus.o_busy[5]); end
        vectors++; if (bus.o_hazard !== 1'b1) begin miscompares++; $display("FAIL issue_hazard: got %b want 1", bus.o_hazard); end
        tick();
        bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd5; bus.i_alu_data = 32'h0000_1234;
        vectors++; if (bus.o_alu_ready !== 1'b1) begin miscompares++; $display("FAIL alu_ready_idle: got %b want 1", bus.o_alu_ready); end
        tick();
        bus.i_alu_valid = 1'b0;
        vectors++; if (bus.o_wr_wren !== 1'b1 || bus.o_wr_addr !== 5'd5 || bus.o_wr_data !== 32'h0000_1234) begin
            miscompares++; $display("FAIL alu_latency: got wren %b addr %0d data %h want 1/5/00001234", bus.o_wr_wren, bus.o_wr_addr, bus.o_wr_data);
        end
        vectors++; if (bus.o_busy[5] !== 1'b1) begin miscompares++; $display("FAIL busy5_wren_cycle: got %b want 1", bus.o_busy[5]); end
`ifdef WB_BYPASS_EN
        vectors++; if (bus.o_hazard !== 1'b0 || bus.o_fwd_rs1_hit !== 1'b1) begin miscompares++; $display("FAIL bypass_rs1: got hazard %b hit %b want 0/1", bus.o_hazard, bus.o_fwd_rs1_hit); end
`else
        vectors++; if (bus.o_hazard !== 1'b1) begin miscompares++; $display("FAIL hazard_wren_cycle: got %b want 1", bus.o_hazard); end
`endif
        tick();
        vectors++; if (bus.o_busy[5] !== 1'b0 || bus.o_hazard !== 1'b0) begin miscompares++; $display("FAIL busy5_cleared: got busy %b hazard %b want 0/0", bus.o_busy[5], bus.o_hazard); end
        vectors++; if (bus.o_wr_wren !== 1'b0) begin miscompares++; $display("FAIL wren_idle: got %b want 0", bus.o_wr_wren); end
        bus.i_rs1_addr = 5'd0;
    endtask

    task automatic test_arbitration();
        int  ai = 0;
        int  li = 0;
        bit  saw_full = 1'b0;
        src_log.delete();
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (ai == 6 && li == 7 && alu_exp.size() == 0 && lsu_exp.size() == 0) break;
            bus.i_alu_valid = (ai < 6);
            bus.i_alu_rd    = 5'(10 + ai);
            bus.i_alu_data  = 32'hA000_0000 + 32'(ai);
            bus.i_lsu_valid = (li < 7);
            bus.i_lsu_rd    = 5'(1 + li);
            bus.i_lsu_data  = 32'h5000_0000 + 32'(li);
            if (bus.o_lsu_ready === 1'b0) saw_full = 1'b1;
            tick();
            if (alu_acc) ai++;
            if (lsu_acc) li++;
        end
        bus.i_alu_valid = 1'b0;
        bus.i_lsu_valid = 1'b0;
        vectors++; if (ai != 6 || li != 7) begin miscompares++; $display("FAIL arb_accept: got alu %0d lsu %0d want 6/7", ai, li); end
        vectors++; if (alu_exp.size() != 0 || lsu_exp.size() != 0) begin miscompares++; $display("FAIL arb_drain: got %0d/%0d pending want 0/0", alu_exp.size(), lsu_exp.size()); end
        vectors++; if (!saw_full) begin miscompares++; $display("FAIL arb_full: got lsu_ready never low want low at count 4"); end
        vectors++; if (src_log.size() != 13) begin miscompares++; $display("FAIL arb_writes: got %0d writes want 13", src_log.size()); end
        for (int i = 0; i < 6 && i < src_log.size(); i++) begin
            vectors++;
            if (src_log[i] !== bit'(i % 2)) begin miscompares++; $display("FAIL arb_alternate[%0d]: got src %0d want %0d", i, src_log[i], i % 2); end
        end
    endtask

    task automatic test_set_wins();
        bus.i_issue_valid = 1'b1; bus.i_issue_wb = 1'b1; bus.i_issue_rd = 5'd7;
        tick();
        bus.i_issue_valid = 1'b0;
        bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd7; bus.i_alu_data = 32'h0000_0077;
        tick();
        bus.i_alu_valid = 1'b0;
        bus.i_issue_valid = 1'b1;
        vectors++; if (bus.o_wr_wren !== 1'b1 || bus.o_wr_addr !== 5'd7) begin miscompares++; $display("FAIL setwin_wren: got wren %b addr %0d want 1/7", bus.o_wr_wren, bus.o_wr_addr); end
        tick();
        bus.i_issue_valid = 1'b0;
        vectors++; if (bus.o_busy[7] !== 1'b1) begin miscompares++; $display("FAIL setwin_busy7: got %b want 1", bus.o_busy[7]); end
        bus.i_alu_valid = 1'b1; bus.i_alu_data = 32'h0000_0078;
        tick();
        bus.i_alu_valid = 1'b0;
        tick();
        vectors++; if (bus.o_busy !== 32'h0) begin miscompares++; $display("FAIL setwin_cleanup: got %h want 0", bus.o_busy); end
    endtask

    task automatic test_rd_zero();
        bus.i_issue_valid = 1'b1; bus.i_issue_wb = 1'b1; bus.i_issue_rd = 5'd3;
        tick();
        bus.i_issue_valid = 1'b0;
        bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd0; bus.i_alu_data = 32'hFFFF_FFFF;
        vectors++; if (bus.o_alu_ready !== 1'b1) begin miscompares++; $display("FAIL rd0_ready: got %b want 1", bus.o_alu_ready); end
        tick();
        bus.i_alu_valid = 1'b0;
        vectors++; if (bus.o_wr_wren !== 1'b0) begin miscompares++; $display("FAIL rd0_wren: got %b want 0", bus.o_wr_wren); end
        vectors++; if (bus.o_busy !== 32'h0000_0008) begin miscompares++; $display("FAIL rd0_busy: got %h want 00000008", bus.o_busy); end
        tick();
        vectors++; if (bus.o_wr_wren !== 1'b0) begin miscompares++; $display("FAIL rd0_wren_late: got %b want 0", bus.o_wr_wren); end
    endtask

    task automatic test_bypass();
        bus.i_issue_valid = 1'b1; bus.i_issue_wb = 1'b1; bus.i_issue_rd = 5'd9;
        tick();
        bus.i_issue_valid = 1'b0;
        bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd9; bus.i_alu_data = 32'h0000_CAFE;
        bus.i_rs1_addr = 5'd0; bus.i_rs2_addr = 5'd9;
        tick();
        bus.i_alu_valid = 1'b0;
        vectors++; if (bus.o_wr_wren !== 1'b1 || bus.o_wr_addr !== 5'd9) begin miscompares++; $display("FAIL byp_wren: got wren %b addr %0d want 1/9", bus.o_wr_wren, bus.o_wr_addr); end
`ifdef WB_BYPASS_EN
        vectors++; if (bus.o_fwd_rs2_hit !== 1'b1 || bus.o_fwd_rs2 !== 32'h0000_CAFE) begin miscompares++; $display("FAIL byp_rs2: got hit %b data %h want 1/0000cafe", bus.o_fwd_rs2_hit, bus.o_fwd_rs2); end
        vectors++; if (bus.o_fwd_rs1_hit !== 1'b0) begin miscompares++; $display("FAIL byp_rs1_x0: got %b want 0", bus.o_fwd_rs1_hit); end
        vectors++; if (bus.o_hazard !== 1'b0) begin miscompares++; $display("FAIL byp_hazard: got %b want 0", bus.o_hazard); end
`else
        vectors++; if (bus.o_hazard !== 1'b1) begin miscompares++; $display("FAIL rs2_hazard: got %b want 1", bus.o_hazard); end
`endif
        tick();
        vectors++; if (bus.o_hazard !== 1'b0 || bus.o_busy[9] !== 1'b0) begin miscompares++; $display("FAIL rs2_release: got hazard %b busy %b want 0/0", bus.o_hazard, bus.o_busy[9]); end
        bus.i_rs2_addr = 5'd0;
    endtask

    task automatic test_reset_midburst();
        int ai = 0;
        int li = 0;
        for (int c = 0; c < 5; c++) begin
            bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'(20 + ai); bus.i_alu_data = 32'hA100_0000 + 32'(ai);
            bus.i_lsu_valid = 1'b1; bus.i_lsu_rd = 5'(1 + li);  bus.i_lsu_data = 32'h5100_0000 + 32'(li);
            tick();
            if (alu_acc) ai++;
            if (lsu_acc) li++;
        end
        vectors++; if (bus.o_wr_wren !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre_wren: got %b want 1", bus.o_wr_wren); end
        vectors++; if (ai != 3 || li != 5) begin miscompares++; $display("FAIL rstmid_accepts: got alu %0d lsu %0d want 3/5", ai, li); end
        #2 rst = 1'b1;
        #1;
        vectors++; if (bus.o_wr_wren !== 1'b0) begin miscompares++; $display("FAIL rstmid_wren: got %b want 0", bus.o_wr_wren); end
        vectors++; if (bus.o_busy !== 32'h0) begin miscompares++; $display("FAIL rstmid_busy: got %h want 0", bus.o_busy); end
        vectors++; if (bus.o_lsu_ready !== 1'b1 || bus.o_alu_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_fifo_empty: got lsu_ready %b alu_ready %b want 1/1", bus.o_lsu_ready, bus.o_alu_ready); end
        bus.i_alu_valid = 1'b0;
        bus.i_lsu_valid = 1'b0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            vectors++; if (bus.o_wr_wren !== 1'b0) begin miscompares++; $display("FAIL rstmid_post[%0d]: got wren %b want 0", c, bus.o_wr_wren); end
        end
    endtask

    initial begin
        bus.i_issue_valid = 1'b0; bus.i_issue_rd = '0; bus.i_issue_wb = 1'b0;
        bus.i_rs1_addr = '0; bus.i_rs2_addr = '0;
        bus.i_alu_valid = 1'b0; bus.i_alu_rd = '0; bus.i_alu_data = '0;
        bus.i_lsu_valid = 1'b0; bus.i_lsu_rd = '0; bus.i_lsu_data = '0;
        test_reset();
        test_alu_write();
        test_arbitration();
        test_set_wins();
        test_rd_zero();
        test_bypass();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
